// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- parametrised UART transmitter.
//
// Sends one character per accepted request: a start bit, DBITS data bits
// LSB first, an optional parity bit, then STOP_BITS stop bits. Each bit
// period is OVS strobes of I_BAUD_TICK, so the bit rate follows the
// external baud generator.
//
// Build option: define UART_TX_PARITY_EN to compile in the I_PAR_EN /
// I_PAR_ODD ports and the parity bit. Without it, frames have no parity.
//
// Parameters:
//   DBITS      data bits per frame (5..9)
//   OVS        baud ticks per bit period (4..32)
//   STOP_BITS  stop bits per frame (1 or 2)
// Ports:
//   I_CLK        clock, rising edge
//   I_RSTF       synchronous active-low reset
//   I_BAUD_TICK  one-cycle oversampling strobe
//   I_TX_START   send request, taken only while O_TX_READY=1
//   I_DATA       character, sampled on the accept edge
//   I_PAR_EN     parity enable, sampled on the accept edge (parity build)
//   I_PAR_ODD    1=odd, 0=even parity, sampled on accept (parity build)
//   O_TX_READY   idle, request can be accepted
//   O_TX_DONE    one-cycle pulse after the last stop bit
//   O_TX         registered serial line, idle high
module uart_tx_cfg #(
    parameter int DBITS     = 8,
    parameter int OVS       = 16,
    parameter int STOP_BITS = 1
) (
    input  logic             I_CLK,
    input  logic             I_RSTF,
    input  logic             I_BAUD_TICK,
    input  logic             I_TX_START,
    input  logic [DBITS-1:0] I_DATA,
`ifdef UART_TX_PARITY_EN
    input  logic             I_PAR_EN,
    input  logic             I_PAR_ODD,
`endif
    output logic             O_TX_READY,
    output logic             O_TX_DONE,
    output logic             O_TX
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DBITS);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVS - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DBITS - 1);
    // The bit counter is reused to count stop bits.
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state;
    logic [TW-1:0]    tick_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [DBITS-1:0] shreg;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             par_en_q;
    logic             par_q;
`endif

    assign bit_end = I_BAUD_TICK && (tick_cnt == LAST_TICK);

    // O_TX is always loaded with the level of the state being entered, so
    // the line changes on the same edge as the state.
    always_ff @(posedge I_CLK) begin
        if (!I_RSTF) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            O_TX       <= 1'b1;
            O_TX_READY <= 1'b1;
            O_TX_DONE  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
`endif
        end else begin
            O_TX_DONE <= 1'b0;

            // Ticks only count once a frame is running; a tick on the
            // accept edge itself is dropped.
            if (state != IDLE && I_BAUD_TICK)
                tick_cnt <= bit_end ? '0 : tick_cnt + TW'(1);

            case (state)
                IDLE: begin
                    if (I_TX_START) begin
                        shreg      <= I_DATA;
                        tick_cnt   <= '0;
                        bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
                        par_en_q   <= I_PAR_EN;
                        par_q      <= (^I_DATA) ^ I_PAR_ODD;
`endif
                        state      <= START;
                        O_TX       <= 1'b0;
                        O_TX_READY <= 1'b0;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state <= DATA;
                        O_TX  <= shreg[0];
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        shreg <= shreg >> 1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                state <= PARITY;
                                O_TX  <= par_q;
                            end else
`endif
                            begin
                                state <= STOP;
                                O_TX  <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            O_TX    <= shreg[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        O_TX  <= 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt    <= '0;
                            state      <= IDLE;
                            O_TX_READY <= 1'b1;
                            O_TX_DONE  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    O_TX       <= 1'b1;
                    O_TX_READY <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: one instance with default parameters (A) and one
// with DBITS=7, OVS=8, STOP_BITS=2 (B). Expected line levels come from a
// frame model: the list of bit levels of the frame, indexed by the number
// of baud ticks seen since the accept edge divided by OVS.
module tb_uart_tx_cfg;
    logic       clk = 1'b0;
    logic       rstf;
    logic       start_a, tick_a, start_b, tick_b;
    logic [8:0] data;
`ifdef UART_TX_PARITY_EN
    logic       pe, po;
`endif
    logic       tx_a, rdy_a, done_a, tx_b, rdy_b, done_b;
    logic       tx_o, rdy_o, done_o;
    bit         sel;
    int         n_assert = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_cfg u_a (
        .I_CLK(clk), .I_RSTF(rstf), .I_BAUD_TICK(tick_a), .I_TX_START(start_a),
        .I_DATA(data[7:0]),
`ifdef UART_TX_PARITY_EN
        .I_PAR_EN(pe), .I_PAR_ODD(po),
`endif
        .O_TX_READY(rdy_a), .O_TX_DONE(done_a), .O_TX(tx_a)
    );

    uart_tx_cfg #(.DBITS(7), .OVS(8), .STOP_BITS(2)) u_b (
        .I_CLK(clk), .I_RSTF(rstf), .I_BAUD_TICK(tick_b), .I_TX_START(start_b),
        .I_DATA(data[6:0]),
`ifdef UART_TX_PARITY_EN
        .I_PAR_EN(pe), .I_PAR_ODD(po),
`endif
        .O_TX_READY(rdy_b), .O_TX_DONE(done_b), .O_TX(tx_b)
    );

    assign tx_o   = sel ? tx_b   : tx_a;
    assign rdy_o  = sel ? rdy_b  : rdy_a;
    assign done_o = sel ? done_b : done_a;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit st, input bit tk);
        if (sel) begin start_b = st; tick_b = tk; end
        else     begin start_a = st; tick_a = tk; end
    endtask

    task automatic idle_check(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            drive(1'b0, 1'b1);
            @(posedge clk); #1;
            chk("idle_tx", tx_o, 1'b1);
            chk("idle_rdy", rdy_o, 1'b1);
            chk("idle_done", done_o, 1'b0);
        end
    endtask

    // tper: 0 = random tick gaps, else one tick every tper cycles.
    // hold: level of I_TX_START after the accept edge.
    // poke_cyc: cycle at which a stray 0x1FF request is pulsed (-1 none).
    // abort_n: return once this many ticks are seen (0 = run to the end).
    task automatic run_frame(input bit s, input logic [8:0] d, input bit pe_i,
                             input bit po_i, input int tper, input bit hold,
                             input int poke_cyc, input int abort_n);
        int ovs, nb, total, n;
        bit p, tk;
        bit bits[$];
        sel = s;
        ovs = s ? 8 : 16;
        nb  = s ? 7 : 8;
        bits.push_back(1'b0);
        p = po_i;
        for (int i = 0; i < nb; i++) begin
            bits.push_back(d[i]);
            p ^= d[i];
        end
        if (pe_i) bits.push_back(p);
        for (int i = 0; i < (s ? 2 : 1); i++) bits.push_back(1'b1);
        total = bits.size() * ovs;

        data = d;
`ifdef UART_TX_PARITY_EN
        pe = pe_i;
        po = po_i;
`endif
        // Tick asserted on the accept edge: it must not count.
        drive(1'b1, 1'b1);
        @(posedge clk); #1;
        chk("accept_tx", tx_o, 1'b0);
        chk("accept_rdy", rdy_o, 1'b0);
        chk("accept_done", done_o, 1'b0);
        // Inputs changing after acceptance must not affect the frame.
        data = 9'($urandom);
`ifdef UART_TX_PARITY_EN
        pe = 1'($urandom);
        po = 1'($urandom);
`endif
        n = 0;
        for (int cyc = 0; n < total; cyc++) begin
            if (cyc >= 20000) begin
                chk_n("frame_timeout", n, total);
                drive(1'b0, 1'b0);
                return;
            end
            tk = (tper == 0) ? ($urandom_range(0, 2) == 0) : ((cyc % tper) == tper - 1);
            if (cyc == poke_cyc) begin
                data = 9'h1FF;
                drive(1'b1, tk);
            end else begin
                drive(hold, tk);
            end
            @(posedge clk); #1;
            if (tk) n++;
            if (n < total) begin
                chk("bit_tx", tx_o, bits[n / ovs]);
                chk("busy_rdy", rdy_o, 1'b0);
                chk("busy_done", done_o, 1'b0);
                if (abort_n != 0 && n == abort_n) return;
            end else begin
                chk("end_tx", tx_o, 1'b1);
                chk("end_rdy", rdy_o, 1'b1);
                chk("end_done", done_o, 1'b1);
                if (tper > 0) chk_n("done_latency", cyc + 1, total * tper);
            end
        end
        drive(hold, 1'b0);
    endtask

    initial begin
        bit rpe, rpo;
        rstf = 1'b0;
        start_a = 1'b0; tick_a = 1'b0; start_b = 1'b0; tick_b = 1'b0;
        data = '0;
`ifdef UART_TX_PARITY_EN
        pe = 1'b0; po = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            chk("rst_tx", tx_o, 1'b1);
            chk("rst_rdy", rdy_o, 1'b1);
            chk("rst_done", done_o, 1'b0);
        end
        rstf = 1'b1;

        // 0x55 at defaults, tick every cycle: 160 cycles to done.
        run_frame(1'b0, 9'h055, 1'b0, 1'b0, 1, 1'b0, -1, 0);
        idle_check(5);

`ifdef UART_TX_PARITY_EN
        // 0x07: odd parity bit 0, even parity bit 1; 176 ticks each.
        run_frame(1'b0, 9'h007, 1'b1, 1'b1, 1, 1'b0, -1, 0);
        idle_check(3);
        run_frame(1'b0, 9'h007, 1'b1, 1'b0, 1, 1'b0, -1, 0);
        idle_check(3);
`endif

        // DBITS=7, OVS=8, 2 stop bits, tick every 3rd cycle: 240 cycles.
        run_frame(1'b1, 9'h041, 1'b0, 1'b0, 3, 1'b0, -1, 0);
        idle_check(5);

        // Stray 0xFF request midway through a 0x00 frame is ignored.
        run_frame(1'b0, 9'h000, 1'b0, 1'b0, 1, 1'b0, 80, 0);
        idle_check(40);

        // Reset during data bit 3 aborts the frame without a done pulse.
        run_frame(1'b0, 9'h0C3, 1'b0, 1'b0, 1, 1'b0, -1, 4 * 16 + 5);
        rstf = 1'b0;
        drive(1'b0, 1'b1);
        @(posedge clk); #1;
        chk("abort_tx", tx_o, 1'b1);
        chk("abort_rdy", rdy_o, 1'b1);
        chk("abort_done", done_o, 1'b0);
        rstf = 1'b1;
        idle_check(40);
        run_frame(1'b0, 9'h0A5, 1'b0, 1'b0, 1, 1'b0, -1, 0);
        idle_check(3);

        // Start held high: back-to-back frames, no idle bit between.
        run_frame(1'b0, 9'h03C, 1'b0, 1'b0, 1, 1'b1, -1, 0);
        run_frame(1'b0, 9'h03C, 1'b0, 1'b0, 1, 1'b1, -1, 0);
        run_frame(1'b0, 9'h03C, 1'b0, 1'b0, 1, 1'b0, -1, 0);
        idle_check(5);

        // Random data, random tick gaps, both instances.
        for (int k = 0; k < 6; k++) begin
            rpe = 1'b0;
            rpo = 1'($urandom);
`ifdef UART_TX_PARITY_EN
            rpe = 1'($urandom);
`endif
            run_frame(k[0], 9'($urandom), rpe, rpo, 0, 1'b0, -1, 0);
            idle_check(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter that replaces the fixed 8N1 serialiser in the serial block. It serialises one character per request at a rate set by an external oversampling baud-tick strobe, with configurable data width, oversampling ratio and stop-bit count, and optional runtime-selectable parity. It sits between the host-side byte interface (or a TX FIFO) and the baud-rate generator.

## Interface
- DBITS, 8, data bits per frame; legal range 5..9
- OVS, 16, baud ticks per bit period; legal range 4..32
- STOP_BITS, 1, stop bits per frame; 1 or 2
- I_CLK  input  1  clock; all logic on the rising edge
- I_RSTF  input  1  reset; synchronous, active-low
- I_BAUD_TICK  input  1  one-cycle oversampling strobe from the baud generator
- I_TX_START  input  1  request to send I_DATA; honoured only when O_TX_READY=1
- I_DATA  input  DBITS  character to send; sampled on the accept edge only
- I_PAR_EN  input  1  parity bit enable; present only with UART_TX_PARITY_EN; sampled on the accept edge
- I_PAR_ODD  input  1  1=odd parity, 0=even; present only with UART_TX_PARITY_EN; sampled on the accept edge
- O_TX_READY  output  1  idle and able to accept a request
- O_TX_DONE  output  1  one-cycle pulse when the final stop bit completes
- O_TX  output  1  serial line; registered; idle-high

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Tick counter: width $clog2(OVS). Bit counter: width $clog2(DBITS). A bit period ends on the I_BAUD_TICK where tick count = OVS-1. The counter clears at that point, otherwise it increments on each tick.
- IDLE: O_TX=1, O_TX_READY=1. I_TX_START=1 is the accept edge:
  - latch I_DATA into the shift register;
  - latch the parity controls;
  - compute parity as XOR of data, inverted if odd;
  - clear the counters;
  - go to START.
- START: O_TX=0 for one bit period, then DATA.
- DATA: O_TX = shift_reg[0], so data goes out LSB first. At the end of each bit period, shift right by 1. After bit DBITS-1, go to PARITY if parity is enabled, otherwise STOP.
- PARITY: O_TX = latched parity bit for one bit period, then STOP.
- STOP: O_TX=1 for STOP_BITS bit periods. At the end of the last one:
  - pulse O_TX_DONE;
  - go to IDLE.
- I_TX_START outside IDLE is ignored. There is no queueing, and the in-flight frame and its latched data are unaffected.
- Changes to I_DATA, I_PAR_EN or I_PAR_ODD after the accept edge have no effect on the current frame.
- Outside IDLE, O_TX_READY=0.

## Timing
- Reset (I_RSTF=0 at a rising edge): state=IDLE, counters=0, shift register=0. Outputs: O_TX=1, O_TX_READY=1, O_TX_DONE=0.
- Reset mid-frame aborts the frame at that edge. O_TX is 1 from the next cycle, and no O_TX_DONE is issued.
- O_TX is a register loaded from the next-state value. It goes low in the cycle immediately after the accept edge.
- Each bit period lasts exactly OVS I_BAUD_TICK strobes, regardless of gaps between ticks.
- Frame length: (1 + DBITS + P + STOP_BITS) × OVS ticks, where P = 1 if parity is enabled, else 0.
- O_TX_DONE is registered. It is high for exactly one cycle: the cycle after the final stop tick, coinciding with O_TX_READY returning to 1.
- A new I_TX_START in the same cycle as O_TX_DONE is accepted, giving back-to-back frames with no extra idle bit.
- I_TX_START and I_BAUD_TICK on the same accept edge: the tick is not counted toward the start bit.

## Configuration
- UART_TX_PARITY_EN defined:
  - I_PAR_EN, I_PAR_ODD and the PARITY state are compiled in;
  - parity is selectable per frame.
- Undefined:
  - the ports are absent, and there is no parity state or logic;
  - frames are always DBITS-N-STOP_BITS;
  - behaviour is identical to the enabled build with I_PAR_EN=0.

## Test plan
- Defaults, I_BAUD_TICK every cycle, send 0x55:
  - O_TX = 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each level 16 cycles;
  - O_TX_DONE pulses exactly 160 cycles after the accept edge.
- Parity build, DBITS=8, send 0x07 with I_PAR_EN=1:
  - with I_PAR_ODD=1, parity bit=0;
  - with I_PAR_ODD=0, parity bit=1;
  - frame length is 176 ticks in both cases.
- DBITS=7, STOP_BITS=2, OVS=8, I_BAUD_TICK every 3rd cycle, send 0x41:
  - 10 bit periods of 24 cycles each;
  - stop high for 48 cycles, then O_TX_DONE.
- I_TX_START pulsed with 0xFF midway through a 0x00 frame: 0x00 frame completes unchanged; O_TX_READY stays 0; no second frame.
- I_RSTF=0 for 1 cycle during DATA bit 3: next cycle O_TX=1, O_TX_READY=1, no O_TX_DONE; a subsequent 0xA5 request transmits correctly.
- I_TX_START held high continuously with 0x3C: frames are back-to-back; start bit begins the cycle after each O_TX_DONE.
